// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame sequencer.
package uart_tx_pkg;

    localparam int   DEFAULT_DATA_WIDTH = 8;
    localparam logic TX_IDLE_LEVEL      = 1'b1;
    localparam logic START_LEVEL        = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Bit-counter width; never below one bit so a 1-bit payload still builds.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake / serial-line bundle between the TX data source, the parity
// calculator and the uart_tx_ctrl frame sequencer.
interface uart_tx_ctrl_if
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_BIT;
    logic                  PAR_LOAD;
    logic                  TX_OUT;
    logic                  BUSY;
    logic                  FRAME_DONE;

    // Data source + parity calculator side.
    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_BIT,
        input  PAR_LOAD, TX_OUT, BUSY, FRAME_DONE
    );

    // Frame sequencer side.
    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_BIT,
        output PAR_LOAD, TX_OUT, BUSY, FRAME_DONE
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register and data-bit counter for the UART TX path.
// ser_bit is the bit that will be on the line in the *next* cycle, so the
// controller can register TX_OUT without an extra cycle of latency.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ser_bit,
    output logic                  last_bit
);
    localparam int CW = cnt_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shreg_reg;
    logic [DATA_WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]         cnt_reg;

    // Next-bit lookahead and end-of-payload detect.
    always_comb begin
        shreg_shifted = shreg_reg >> 1;
        ser_bit       = shift_en ? shreg_shifted[0] : shreg_reg[0];
        last_bit      = (cnt_reg == CW'(DATA_WIDTH - 1));
    end

    // Capture on load, shift right and count while data bits are on the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            shreg_reg <= load_data;
            cnt_reg   <= '0;
        end else if (shift_en) begin
            shreg_reg <= shreg_shifted;
            cnt_reg   <= last_bit ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop.
// Optional build macro UART_TX_TWO_STOP_EN stretches STOP to two cycles.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_ctrl_if.slave bus
);
    tx_state_e state_reg, state_next;
    logic      par_en_reg;
    logic      tx_out_reg, tx_out_next;
    logic      busy_reg, busy_next;
    logic      frame_done_reg, frame_done_next;
    logic      final_stop, final_stop_next;
    logic      ready, accept;
    logic      ser_bit, last_bit;

`ifdef UART_TX_TWO_STOP_EN
    logic stop2_reg;
    logic stop2_next;

    // Second STOP cycle is the one after the first.
    assign stop2_next      = (state_reg == STOP) && !stop2_reg;
    assign final_stop      = (state_reg == STOP) && stop2_reg;
    assign final_stop_next = stop2_next;

    // Tracks which of the two stop cycles is on the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stop2_reg <= 1'b0;
        end else begin
            stop2_reg <= stop2_next;
        end
    end
`else
    assign final_stop      = (state_reg == STOP);
    assign final_stop_next = 1'b1;
`endif

    // Reset gates the strobe so the parity calculator never loads during reset.
    assign ready        = (state_reg == IDLE) || final_stop;
    assign accept       = bus.DATA_VALID && ready && RST;
    assign bus.PAR_LOAD = accept;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (accept),
        .shift_en  (state_reg == DATA),
        .load_data (bus.P_DATA),
        .ser_bit   (ser_bit),
        .last_bit  (last_bit)
    );

    // Next state plus the line level / flags for the state being entered.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = START;
            START:   state_next = DATA;
            DATA:    if (last_bit) state_next = par_en_reg ? PARITY : STOP;
            PARITY:  state_next = STOP;
            STOP:    if (final_stop) state_next = accept ? START : IDLE;
            default: state_next = IDLE;
        endcase

        tx_out_next = TX_IDLE_LEVEL;
        case (state_next)
            START:   tx_out_next = START_LEVEL;
            DATA:    tx_out_next = ser_bit;
            PARITY:  tx_out_next = bus.PAR_BIT;
            default: tx_out_next = TX_IDLE_LEVEL;
        endcase

        busy_next       = (state_next != IDLE);
        frame_done_next = (state_next == STOP) && final_stop_next;
    end

    // State, latched parity enable and registered line outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg      <= IDLE;
            par_en_reg     <= 1'b0;
            tx_out_reg     <= TX_IDLE_LEVEL;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tx_out_reg     <= tx_out_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
            if (accept) begin
                par_en_reg <= bus.PAR_EN;
            end
        end
    end

    assign bus.TX_OUT     = tx_out_reg;
    assign bus.BUSY       = busy_reg;
    assign bus.FRAME_DONE = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl with a behavioural parity
// calculator. Honours UART_TX_TWO_STOP_EN when the bundle is built with it.
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic odd_mode = 1'b0;
    int   par_load_cnt = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 CLK = ~CLK;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Parity calculator model: registers parity of P_DATA on its load strobe.
    always @(posedge CLK or negedge RST) begin
        if (!RST) bus.PAR_BIT <= 1'b0;
        else if (bus.PAR_LOAD) bus.PAR_BIT <= (^bus.P_DATA) ^ odd_mode;
    end

    always @(posedge CLK) begin
        if (bus.PAR_LOAD) par_load_cnt <= par_load_cnt + 1;
    end

    // Present a byte at a falling edge; the DUT accepts at the next rising edge.
    task automatic start_frame(input logic [7:0] d, input logic pe);
        @(negedge CLK);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.DATA_VALID = 1'b1;
        #1;
    endtask

    // Sample len cycles of the line, dropping DATA_VALID after the start bit.
    task automatic capture(input int len, output logic [0:15] tx,
                           output logic [0:15] busy, output logic [0:15] done);
        tx = '1; busy = '0; done = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            tx[i] = bus.TX_OUT; busy[i] = bus.BUSY; done[i] = bus.FRAME_DONE;
            if (i == 0) bus.DATA_VALID = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        bus.DATA_VALID = 1'b1;
        bus.P_DATA = 8'h5A;
        bus.PAR_EN = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        tests_run++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0 || bus.FRAME_DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got tx=%b busy=%b done=%b, expected 1 0 0", bus.TX_OUT, bus.BUSY, bus.FRAME_DONE);
        end
        tests_run++;
        if (bus.PAR_LOAD !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_par_load: got %b, expected 0", bus.PAR_LOAD);
        end
        bus.DATA_VALID = 1'b0;
        @(negedge CLK) RST = 1'b1;
        @(negedge CLK);
        tests_run++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got tx=%b busy=%b, expected 1 0", bus.TX_OUT, bus.BUSY);
        end
        $display("[TB] reset: idle line checked");
    endtask

    // 8'hA5 without parity: 0,1,0,1,0,0,1,0,1 then stop(s).
    task automatic test_no_parity(input string name);
        logic [0:15] exp, tx, busy, done;
        int len, lc0;
        exp = 16'b0101_0010_1111_1111;
        len = 1 + DW + STOPS;
        lc0 = par_load_cnt;
        start_frame(8'hA5, 1'b0);
        tests_run++;
        if (bus.PAR_LOAD !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_par_load: got %b, expected 1", name, bus.PAR_LOAD);
        end
        capture(len, tx, busy, done);
        for (int i = 0; i < len; i++) begin
            tests_run++;
            if (tx[i] !== exp[i] || busy[i] !== 1'b1 || done[i] !== (i == len - 1)) begin
                tests_failed++;
                $display("FAIL %s_bit[%0d]: got tx=%b busy=%b done=%b, expected %b 1 %b", name, i, tx[i], busy[i], done[i], exp[i], (i == len - 1));
            end
        end
        @(negedge CLK);
        tests_run++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0 || bus.FRAME_DONE !== 1'b0 || par_load_cnt - lc0 !== 1) begin
            tests_failed++;
            $display("FAIL %s_end: got tx=%b busy=%b done=%b loads=%0d, expected 1 0 0 1", name, bus.TX_OUT, bus.BUSY, bus.FRAME_DONE, par_load_cnt - lc0);
        end
        $display("[TB] %s: 8'hA5 frame of %0d bits checked", name, len);
    endtask

    // 8'h3C with parity: even mode gives parity 0, odd mode gives 1.
    task automatic test_parity();
        logic [0:15] exp [2];
        logic [0:15] tx, busy, done;
        int len;
        exp[0] = 16'b0001_1110_0011_1111;
        exp[1] = 16'b0001_1110_0111_1111;
        len = 1 + DW + 1 + STOPS;
        for (int m = 0; m < 2; m++) begin
            odd_mode = (m == 1);
            start_frame(8'h3C, 1'b1);
            capture(len, tx, busy, done);
            for (int i = 0; i < len; i++) begin
                tests_run++;
                if (tx[i] !== exp[m][i] || busy[i] !== 1'b1 || done[i] !== (i == len - 1)) begin
                    tests_failed++;
                    $display("FAIL parity_m%0d_bit[%0d]: got tx=%b busy=%b done=%b, expected %b 1 %b", m, i, tx[i], busy[i], done[i], exp[m][i], (i == len - 1));
                end
            end
            @(negedge CLK);
            $display("[TB] parity: 8'h3C odd_mode=%0d frame of %0d bits checked", m, len);
        end
        odd_mode = 1'b0;
    endtask

    // DATA_VALID held high: 8'h55 then 8'hAA accepted in the final stop cycle.
    task automatic test_back_to_back();
        logic [0:8] f1, f2;
        logic exp_tx;
        int fl, lc0, j;
        f1 = 9'b0_1010_1010;
        f2 = 9'b0_0101_0101;
        fl = 1 + DW + STOPS;
        lc0 = par_load_cnt;
        start_frame(8'h55, 1'b0);
        for (int i = 0; i < 2 * fl; i++) begin
            @(negedge CLK);
            j = i % fl;
            exp_tx = (j < 9) ? ((i < fl) ? f1[j] : f2[j]) : 1'b1;
            tests_run++;
            if (bus.TX_OUT !== exp_tx || bus.BUSY !== 1'b1 || bus.FRAME_DONE !== (j == fl - 1)) begin
                tests_failed++;
                $display("FAIL b2b_bit[%0d]: got tx=%b busy=%b done=%b, expected %b 1 %b", i, bus.TX_OUT, bus.BUSY, bus.FRAME_DONE, exp_tx, (j == fl - 1));
            end
            if (i == 1) bus.P_DATA = 8'hAA;
            if (i == fl + 1) bus.DATA_VALID = 1'b0;
        end
        @(negedge CLK);
        tests_run++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0 || par_load_cnt - lc0 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_end: got tx=%b busy=%b loads=%0d, expected 1 0 2", bus.TX_OUT, bus.BUSY, par_load_cnt - lc0);
        end
        $display("[TB] back_to_back: 8'h55 + 8'hAA, %0d loads", par_load_cnt - lc0);
    endtask

    // 8'hFF offered mid-frame must be ignored.
    task automatic test_ignore_busy();
        logic [0:15] exp;
        int len, lc0;
        exp = 16'b0001_1110_0111_1111;
        len = 1 + DW + STOPS;
        lc0 = par_load_cnt;
        start_frame(8'h3C, 1'b0);
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            tests_run++;
            if (bus.TX_OUT !== exp[i] || bus.BUSY !== 1'b1) begin
                tests_failed++;
                $display("FAIL ignore_bit[%0d]: got tx=%b busy=%b, expected %b 1", i, bus.TX_OUT, bus.BUSY, exp[i]);
            end
            if (i == 0) bus.DATA_VALID = 1'b0;
            if (i == 4) begin
                bus.P_DATA = 8'hFF;
                bus.DATA_VALID = 1'b1;
                #1;
                tests_run++;
                if (bus.PAR_LOAD !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ignore_par_load: got %b, expected 0", bus.PAR_LOAD);
                end
            end
            if (i == 5) bus.DATA_VALID = 1'b0;
        end
        @(negedge CLK);
        tests_run++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0 || par_load_cnt - lc0 !== 1) begin
            tests_failed++;
            $display("FAIL ignore_end: got tx=%b busy=%b loads=%0d, expected 1 0 1", bus.TX_OUT, bus.BUSY, par_load_cnt - lc0);
        end
        $display("[TB] ignore_busy: 8'hFF during DATA ignored");
    endtask

    // Reset during the fourth data bit of 8'hA5, then a clean frame.
    task automatic test_reset_mid_frame();
        start_frame(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (i == 0) bus.DATA_VALID = 1'b0;
        end
        tests_run++;
        if (bus.TX_OUT !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_pre: got tx=%b, expected 0", bus.TX_OUT);
        end
        RST = 1'b0;
        #1;
        tests_run++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0 || bus.FRAME_DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_async: got tx=%b busy=%b done=%b, expected 1 0 0", bus.TX_OUT, bus.BUSY, bus.FRAME_DONE);
        end
        @(negedge CLK) RST = 1'b1;
        @(negedge CLK);
        $display("[TB] reset_mid_frame: async return to idle checked");
        test_no_parity("after_reset");
    endtask

    // 8'h00 with even parity; a request in the first stop cycle is honoured
    // only when that cycle is the final one.
    task automatic test_stop_accept();
        logic [0:15] exp;
        logic exp_first;
        int len;
        exp = 16'b0000_0000_0011_1111;
        len = 1 + DW + 1 + STOPS;
        exp_first = (STOPS == 1);
        start_frame(8'h00, 1'b1);
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            tests_run++;
            if (bus.TX_OUT !== exp[i] || bus.FRAME_DONE !== (i == len - 1)) begin
                tests_failed++;
                $display("FAIL stop_bit[%0d]: got tx=%b done=%b, expected %b %b", i, bus.TX_OUT, bus.FRAME_DONE, exp[i], (i == len - 1));
            end
            if (i == 0) bus.DATA_VALID = 1'b0;
            if (i == 10) begin
                bus.DATA_VALID = 1'b1;
                #1;
                tests_run++;
                if (bus.PAR_LOAD !== exp_first) begin
                    tests_failed++;
                    $display("FAIL stop_first_accept: got %b, expected %b", bus.PAR_LOAD, exp_first);
                end
            end
            if (i == len - 1) begin
                #1;
                tests_run++;
                if (bus.PAR_LOAD !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stop_final_accept: got %b, expected 1", bus.PAR_LOAD);
                end
            end
        end
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
        tests_run++;
        if (bus.TX_OUT !== 1'b0 || bus.BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL stop_next_start: got tx=%b busy=%b, expected 0 1", bus.TX_OUT, bus.BUSY);
        end
        repeat (len) @(negedge CLK);
        tests_run++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_drain: got tx=%b busy=%b, expected 1 0", bus.TX_OUT, bus.BUSY);
        end
        $display("[TB] stop_accept: 8'h00 frame of %0d bits, %0d stop cycle(s)", len, STOPS);
    endtask

    initial begin
        bus.P_DATA = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN = 1'b0;
        test_reset();
        test_no_parity("no_parity");
        test_parity();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        test_stop_accept();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmit path. Accepts a parallel byte with a valid strobe and captures it. Strobes the external parity calculator and serializes start, data (LSB first), optional parity and stop bits onto TX_OUT, one bit per CLK cycle (CLK is the bit clock). Sits between the TX data source and the serial line; owns the parity calculator's load strobe.

Parameters:
DATA_WIDTH, 8, payload bits per frame (the parity calculator is sized to match).

Ports:
CLK       input   1           bit-rate clock
RST       input   1           asynchronous, active-low reset
P_DATA    input   DATA_WIDTH  parallel payload; also wired straight to the parity calculator's DATA
DATA_VALID input  1           payload valid; sampled only when the block is ready
PAR_EN    input   1           1 = insert parity bit; sampled at acceptance
PAR_BIT   input   1           registered parity result from the parity calculator
PAR_LOAD  output  1           combinational; drives the parity calculator's DATA_VALID
TX_OUT    output  1           serial line, registered, idles high
BUSY      output  1           registered; high while a frame is in flight
FRAME_DONE output 1           registered one-cycle pulse in the last stop-bit cycle

Behaviour:
- Reset (RST low, async): state IDLE, TX_OUT=1, BUSY=0, FRAME_DONE=0, bit counter=0, shift register=0, latched PAR_EN=0. PAR_LOAD=0 while RST is low.
- ready = (state==IDLE) or (state==STOP, final stop cycle).
- accept = DATA_VALID & ready.
- PAR_LOAD = accept, combinational. The parity calculator registers parity of P_DATA at the same edge, so PAR_BIT is valid from the next cycle.
- On accept edge:
  - shift register <= P_DATA
  - latched PAR_EN <= PAR_EN
  - state <= START
- DATA_VALID while not ready is ignored: no capture, no PAR_LOAD, no error.
- States (encoding one-hot or binary, implementer's choice):
  - IDLE: TX_OUT=1, BUSY=0.
  - START: TX_OUT=0, BUSY=1, one cycle -> DATA.
  - DATA: TX_OUT=shreg[0]; shift right each cycle; counter 0..DATA_WIDTH-1.
    - At count DATA_WIDTH-1 -> PARITY if latched PAR_EN, else STOP.
  - PARITY: TX_OUT=PAR_BIT, one cycle -> STOP.
  - STOP: TX_OUT=1, FRAME_DONE=1 in the final stop cycle.
    - Next state: START if accept, else IDLE.
- Output timing: outputs are registered, so TX_OUT for a state appears in the cycle the state is occupied. Accept at edge k gives the start bit during cycle k+1.
- Frame length: 1+DATA_WIDTH+PAR_EN+1 cycles (default 10 or 11).
- Back-to-back frames: accept during the final STOP cycle gives a start bit immediately afterwards, with no idle gap. BUSY stays high across the boundary.
- Counter width: clog2(DATA_WIDTH); it must not wrap inside DATA.
- PAR_EN or P_DATA changes mid-frame have no effect on the current frame.
- Reset mid-frame: immediate return to IDLE with TX_OUT=1. No partial frame resumes.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: STOP lasts two cycles. FRAME_DONE and ready apply only in the second stop cycle. Frame is 12 cycles with parity.
- Undefined: single stop cycle as above; no second-stop logic is synthesized.

Decomposition:
- Package uart_tx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - TX_IDLE_LEVEL=1'b1 and START_LEVEL=1'b0 constants
  - default DATA_WIDTH
- One natural sub-module: uart_tx_serializer, covering the shift register and bit counter.
  - Inputs: load, shift_en.
  - Outputs: ser_bit, last_bit.
- The FSM, output mux and PAR_LOAD stay in uart_tx_ctrl.
- The parity calculator is instantiated alongside, in the TX top, not inside this block.

Test Plan:
1. Reset, then P_DATA=8'hA5, PAR_EN=0, one-cycle DATA_VALID -> PAR_LOAD pulses once; TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; BUSY high for 10 cycles; FRAME_DONE in cycle 10.
2. P_DATA=8'h3C, PAR_EN=1, calculator in even mode -> 11-bit frame 0,0,0,1,1,1,1,0,0,0,1 (parity 0). Repeat with odd mode -> parity bit 1.
3. DATA_VALID held high continuously with 8'h55 then 8'hAA on a stop-cycle accept -> second start bit directly follows the first stop bit; BUSY never drops; exactly two PAR_LOAD pulses.
4. DATA_VALID pulsed during DATA state with 8'hFF -> ignored; current frame bits unchanged; no PAR_LOAD; TX_OUT=1 afterwards.
5. RST asserted during the fourth data bit -> TX_OUT=1 and BUSY=0 asynchronously; the next accepted byte produces a clean full frame.
6. With UART_TX_TWO_STOP_EN: 8'h00, PAR_EN=1 -> 12 cycles ending with 1,1; accept only honoured in the second stop cycle.
